// File: rtl/half_to_fixed.sv
// half_to_fixed: reads an IEEE-754 half-precision operand from the byte-wide data
// memory and writes back the equivalent 16-bit sign-magnitude integer
// (truncated toward zero, saturating at 0x7FFF). The mantissa is aligned by a
// single-bit shifter, one position per cycle.
module half_to_fixed #(
    parameter int unsigned AW       = 8,
    parameter int unsigned SRC_ADDR = 0,
    parameter int unsigned DST_ADDR = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] DataAddress,
    output logic          ReadMem,
    output logic          WriteMem,
    output logic [7:0]    DataIn,
    input  logic [7:0]    DataOut
);

    localparam logic [AW-1:0] SrcLo = AW'(SRC_ADDR);
    localparam logic [AW-1:0] SrcHi = AW'(SRC_ADDR + 1);
    localparam logic [AW-1:0] DstLo = AW'(DST_ADDR);
    localparam logic [AW-1:0] DstHi = AW'(DST_ADDR + 1);

    typedef enum logic [2:0] {
        StIdle,
        StRdLo,
        StRdHi,
        StClass,
        StShift,
        StWrLo,
        StWrHi,
        StDone
    } state_t;

    state_t      state_q;
    logic [15:0] op_q;
    logic [14:0] w_q;
    logic        shl_q;
    logic [3:0]  cnt_q;
    logic        sign_q;

    logic [4:0]  exp_f;
    logic [9:0]  man_f;
    logic [3:0]  n_right;
    logic [3:0]  n_left;
    logic [15:0] res;

    assign exp_f   = op_q[14:10];
    assign man_f   = op_q[9:0];
    // Only meaningful for 15 <= exp <= 24 and 25 <= exp <= 29 respectively.
    assign n_right = 4'(5'd25 - exp_f);
    assign n_left  = 4'(exp_f - 5'd25);
    // sign_q is cleared whenever the magnitude is zero or the operand is NaN.
    assign res     = {sign_q, w_q};

    // Control FSM and datapath registers, with registered busy/done flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b0;
            op_q    <= '0;
            w_q     <= '0;
            shl_q   <= 1'b0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q <= StRdLo;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                StRdLo: begin
                    op_q[7:0] <= DataOut;
                    state_q   <= StRdHi;
                end
                StRdHi: begin
                    op_q[15:8] <= DataOut;
                    state_q    <= StClass;
                end
                StClass: begin
                    shl_q <= 1'b0;
                    cnt_q <= '0;
                    if (exp_f < 5'd15) begin
                        // Below 1.0 (including zero and subnormals) truncates to 0.
                        w_q     <= '0;
                        sign_q  <= 1'b0;
                        state_q <= StWrLo;
                    end else if (exp_f < 5'd25) begin
                        w_q     <= {4'b0, 1'b1, man_f};
                        sign_q  <= op_q[15];
                        cnt_q   <= n_right;
                        state_q <= StShift;
                    end else if (exp_f < 5'd30) begin
                        w_q     <= {4'b0, 1'b1, man_f};
                        sign_q  <= op_q[15];
                        shl_q   <= 1'b1;
                        cnt_q   <= n_left;
                        state_q <= (exp_f == 5'd25) ? StWrLo : StShift;
                    end else if (exp_f == 5'd31 && man_f != 10'd0) begin
                        // NaN: saturate with positive sign.
                        w_q     <= 15'h7FFF;
                        sign_q  <= 1'b0;
                        state_q <= StWrLo;
                    end else begin
                        w_q     <= 15'h7FFF;
                        sign_q  <= op_q[15];
                        state_q <= StWrLo;
                    end
                end
                StShift: begin
                    w_q   <= shl_q ? (w_q << 1) : (w_q >> 1);
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= StWrLo;
                    end
                end
                StWrLo: begin
                    state_q <= StWrHi;
                end
                StWrHi: begin
                    state_q <= StDone;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    // Memory port decode, driven from the state register only.
    always_comb begin
        DataAddress = '0;
        ReadMem     = 1'b0;
        WriteMem    = 1'b0;
        DataIn      = 8'h00;
        case (state_q)
            StRdLo: begin
                DataAddress = SrcLo;
                ReadMem     = 1'b1;
            end
            StRdHi: begin
                DataAddress = SrcHi;
                ReadMem     = 1'b1;
            end
            StWrLo: begin
                DataAddress = DstLo;
                DataIn      = res[7:0];
                WriteMem    = 1'b1;
            end
            StWrHi: begin
                DataAddress = DstHi;
                DataIn      = res[15:8];
                WriteMem    = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
